opt_rand_gen: RTL
=================

Name: opt_rand_gen

Overview:
- Per-node random source that sits directly upstream of two_node.
- Drives two_node's K, L, r_metropolis and r_exchange inputs, so each node draws its own optimisation move and test randoms.
- Uses a xorshift64 generator with rejection sampling, so K and L are always legal city indices for the selected move type.
- Sequenced by the same random_init / random_run strobes that the controller already broadcasts to every node.

Parameters:
- CITY_NUM, 100: number of cities. Legal K/L range is 1..CITY_NUM-1. Must be 4..128.
- SEED_RESET, 64'h0123_4567_89AB_CDEF: generator state loaded at reset. Must be non-zero.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- random_init  in  1  one-cycle strobe; load random_seed into the generator
- random_seed  in  64  seed value
- random_run  in  1  one-cycle strobe; start one draw
- two_opt  in  1  move type for this draw: 0 = or-opt, 1 = 2-opt
- ready  out  1  idle; outputs hold a complete draw
- K  out  7  first city index
- L  out  7  second city index
- r_metropolis  out  32  uniform random for the metropolis test
- r_exchange  out  32  uniform random for the replica exchange test

Behaviour:
- Generator step (one per cycle while drawing, combinational from current state s):
  - t = s ^ (s<<13); t = t ^ (t>>7); n = t ^ (t<<17); s <= n.
  - "n" below always means the value produced this cycle.
- Zero seed: random_init with random_seed == 0 loads 64'h1 instead, because xorshift locks up at zero.
- States:
  - IDLE: ready=1.
  - DRAW_K, DRAW_L, DRAW_R: ready=0.
- IDLE:
  - random_init: load seed, stay IDLE, outputs unchanged.
  - Otherwise random_run: latch two_opt into mode_q, go to DRAW_K. The generator does not step on this cycle.
  - Otherwise no change.
- DRAW_K:
  - Step the generator; c = n[6:0].
  - c accepted if 1 <= c <= CITY_NUM-1: k_q <= c, go to DRAW_L.
  - Otherwise stay in DRAW_K (rejection) and retry next cycle.
- DRAW_L:
  - Step the generator; c = n[6:0].
  - c accepted if all hold:
    - 1 <= c <= CITY_NUM-1;
    - c != k_q;
    - if mode_q = 1: |c - k_q| >= 2, compared as 8-bit unsigned difference.
  - Accept: l_q <= c, go to DRAW_R.
  - Reject: stay in DRAW_L; k_q is kept.
- DRAW_R:
  - Step the generator. r_metropolis <= n[63:32]; r_exchange <= n[31:0].
  - If mode_q = 0: K <= k_q, L <= l_q.
  - If mode_q = 1: K <= min(k_q, l_q), L <= max(k_q, l_q).
  - All four outputs update on the same edge. Go to IDLE.
- Latency:
  - random_run sampled at edge e: ready=0 after e.
  - With no rejections, outputs and ready=1 are valid after edge e+3.
  - Each rejection adds 1 cycle. There is no retry limit; with CITY_NUM=100 the acceptance rate is about 77% per draw.
- Outputs are stable whenever ready=1 and change only on the DRAW_R edge.
- random_run while ready=0 is ignored; it is not queued.
- random_init in DRAW_*:
  - Aborts the draw, loads the seed, returns to IDLE.
  - Outputs keep the previous complete draw; a partial K is never exposed.
- random_init and random_run on the same cycle: init wins, run is dropped.
- two_opt changing mid-draw has no effect; mode_q is used.
- Reset (asynchronous, any state):
  - s = SEED_RESET, state = IDLE, ready = 1.
  - K = 1, L = 3, r_metropolis = 0, r_exchange = 0, k_q = 1, l_q = 3, mode_q = 0.
- Reset deasserting mid-run behaves exactly as a fresh reset.

Test Plan:
- Reset: assert reset low during random activity -> ready=1, K=1, L=3, r_metropolis=0, r_exchange=0; hold for 10 cycles with no strobes -> no output change.
- Seed 1, two_opt=0:
  - Pulse random_run -> first generator step gives n = 64'h40822041, so K=65.
  - L, r_metropolis and r_exchange match the bench xorshift64 reference model.
  - ready returns high 3 cycles after the run edge plus the model-predicted rejection count.
- Seed 0: random_init with random_seed=0, then random_run -> identical results to seed 1; generator never stuck at zero.
- 2-opt legality:
  - 10,000 runs with two_opt=1, CITY_NUM=100, varied seeds.
  - Every result satisfies 1 <= K, K+2 <= L, L <= 99.
  - With two_opt=0, every result satisfies K != L and both are in 1..99.
- Abort and collision:
  - random_init during DRAW_L -> IDLE next cycle, outputs equal the previous draw.
  - random_run while ready=0 is ignored.
  - Simultaneous random_init and random_run -> seed loaded, ready stays 1.
- Mid-draw reset: reset asserted in DRAW_K -> all reset values immediately (asynchronous), generator state = SEED_RESET; next run matches the model seeded with SEED_RESET.

Source files
------------

// File: rtl/opt_rand_gen.sv
// Purpose: per-node xorshift64 random source for two_node (K, L and the two test randoms).
// Latency: outputs valid 3 cycles after random_run is sampled, +1 cycle per rejected candidate.
// Backpressure: none; random_run while busy is dropped, random_init aborts any draw.
//
// Ports:
//   clk, reset (async, active-low)
//   random_init / random_seed : load a new generator seed (zero seed is replaced by 1)
//   random_run / two_opt      : start one draw; two_opt selects 2-opt (1) or or-opt (0)
//   ready                     : idle, outputs hold a complete draw
//   K, L                      : city indices in 1..CITY_NUM-1
//   r_metropolis, r_exchange  : 32-bit uniform randoms
module opt_rand_gen #(
  parameter int          CITY_NUM   = 100,
  parameter logic [63:0] SEED_RESET = 64'h0123_4567_89AB_CDEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        random_init,
  input  logic [63:0] random_seed,
  input  logic        random_run,
  input  logic        two_opt,
  output logic        ready,
  output logic [6:0]  K,
  output logic [6:0]  L,
  output logic [31:0] r_metropolis,
  output logic [31:0] r_exchange
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW_K = 2'd1,
    DRAW_L = 2'd2,
    DRAW_R = 2'd3
  } state_t;

  localparam logic [7:0] MAX_IDX = 8'(CITY_NUM - 1);

  state_t      state_q;
  logic [63:0] s_q;
  logic        mode_q;
  logic [6:0]  k_q;
  logic [6:0]  l_q;
  logic        ready_q;
  logic [6:0]  k_out_q;
  logic [6:0]  l_out_q;
  logic [31:0] rm_q;
  logic [31:0] re_q;

  // Generator step and candidate qualification, all from the current state.
  logic [63:0] t1;
  logic [63:0] t2;
  logic [63:0] s_d;
  logic [6:0]  cand;
  logic        cand_in_range;
  logic [7:0]  cand_diff;
  logic        k_ok;
  logic        l_ok;
  logic [63:0] seed_d;
  logic [6:0]  kl_min;
  logic [6:0]  kl_max;

  always_comb begin
    t1            = s_q ^ (s_q << 13);
    t2            = t1 ^ (t1 >> 7);
    s_d           = t2 ^ (t2 << 17);
    cand          = s_d[6:0];
    cand_in_range = (cand != 7'd0) && ({1'b0, cand} <= MAX_IDX);
    cand_diff     = (cand >= k_q) ? ({1'b0, cand} - {1'b0, k_q})
                                  : ({1'b0, k_q} - {1'b0, cand});
    k_ok          = cand_in_range;
    // 2-opt needs at least one city between the two cut points.
    l_ok          = cand_in_range && (cand != k_q) && (!mode_q || (cand_diff >= 8'd2));
    // xorshift has a fixed point at zero, so never load it.
    seed_d        = (random_seed == 64'd0) ? 64'd1 : random_seed;
    kl_min        = (k_q < l_q) ? k_q : l_q;
    kl_max        = (k_q < l_q) ? l_q : k_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_q     <= SEED_RESET;
      mode_q  <= 1'b0;
      k_q     <= 7'd1;
      l_q     <= 7'd3;
      ready_q <= 1'b1;
      k_out_q <= 7'd1;
      l_out_q <= 7'd3;
      rm_q    <= 32'd0;
      re_q    <= 32'd0;
    end else if (random_init) begin
      // Init wins in every state: abort any draw, keep the last complete outputs.
      s_q     <= seed_d;
      state_q <= IDLE;
      ready_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (random_run) begin
            mode_q  <= two_opt;
            state_q <= DRAW_K;
            ready_q <= 1'b0;
          end
        end
        DRAW_K: begin
          s_q <= s_d;
          if (k_ok) begin
            k_q     <= cand;
            state_q <= DRAW_L;
          end
        end
        DRAW_L: begin
          s_q <= s_d;
          if (l_ok) begin
            l_q     <= cand;
            state_q <= DRAW_R;
          end
        end
        DRAW_R: begin
          s_q     <= s_d;
          rm_q    <= s_d[63:32];
          re_q    <= s_d[31:0];
          k_out_q <= mode_q ? kl_min : k_q;
          l_out_q <= mode_q ? kl_max : l_q;
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready        = ready_q;
  assign K            = k_out_q;
  assign L            = l_out_q;
  assign r_metropolis = rm_q;
  assign r_exchange   = re_q;

endmodule
